// File: rtl/edge_event_arbiter_if.sv
// Event port between the edge-event arbiter and its downstream consumer.
// The arbiter drives the master side and the consumer drives the slave side.
interface edge_event_arbiter_if #(
    parameter int CH_W = 2
) ();
    logic            ev_valid;
    logic            ev_ready;
    logic [CH_W-1:0] ev_ch;
    logic            ev_pol;

    modport master (output ev_valid, output ev_ch, output ev_pol, input ev_ready);
    modport slave  (input ev_valid, input ev_ch, input ev_pol, output ev_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection with pending/overflow tracking.
// Events are serialised onto one valid/ready port by a round-robin arbiter.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_CH-1:0]       d,
    input  logic [2*N_CH-1:0]     mode,
    edge_event_arbiter_if.master  ev,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       ovf,
    input  logic [N_CH-1:0]       ovf_clr
);

    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] pol_q, pol_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic            ev_valid_q, ev_valid_d;
    logic [CH_W-1:0] ev_ch_q, ev_ch_d;
    logic            ev_pol_q, ev_pol_d;
    logic [CH_W-1:0] last_q, last_d;

    logic [N_CH-1:0] rise, fall, qe, pop;
    logic            slot_free, load, win_found;
    logic [CH_W-1:0] win_idx;

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_qual
        assign qe[g] = (rise[g] & mode[2*g]) | (fall[g] & mode[2*g+1]);
    end

    // Search begins one past the last grant and wraps, so every channel gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            int idx;
            idx = (int'(last_q) + k) % N_CH;
            if (!win_found && pend_q[idx]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(idx);
            end
        end
    end

    assign slot_free = ~ev_valid_q | ev.ev_ready;
    assign load      = slot_free & win_found;
    assign pop       = load ? ({{(N_CH-1){1'b0}}, 1'b1} << win_idx) : '0;

    // A fresh edge on the channel being popped re-arms it rather than overflowing.
    assign pend_d = qe | (pend_q & ~pop);
    assign pol_d  = (qe & rise) | (~qe & pol_q);
    assign ovf_d  = (qe & pend_q & ~pop) | (ovf_q & ~ovf_clr);

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_ch_d    = ev_ch_q;
        ev_pol_d   = ev_pol_q;
        last_d     = last_q;
        if (load) begin
            ev_valid_d = 1'b1;
            ev_ch_d    = win_idx;
            ev_pol_d   = pol_q[win_idx];
            last_d     = win_idx;
        end else if (slot_free) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q     <= '0;
            pend_q     <= '0;
            pol_q      <= '0;
            ovf_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            ev_pol_q   <= 1'b0;
            last_q     <= CH_W'(N_CH - 1);
        end else begin
            prev_q     <= d;
            pend_q     <= pend_d;
            pol_q      <= pol_d;
            ovf_q      <= ovf_d;
            ev_valid_q <= ev_valid_d;
            ev_ch_q    <= ev_ch_d;
            ev_pol_q   <= ev_pol_d;
            last_q     <= last_d;
        end
    end

    assign ev.ev_valid = ev_valid_q;
    assign ev.ev_ch    = ev_ch_q;
    assign ev.ev_pol   = ev_pol_q;
    assign pending     = pend_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter (N_CH=4) with
// hand-written sequences for backpressure, async reset and round-robin order.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] d;
    logic [7:0] mode;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    edge_event_arbiter_if #(.CH_W(2)) ev_if ();

    edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .d       (d),
        .mode    (mode),
        .ev      (ev_if.master),
        .pending (pending),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic [7:0]  mode;
        logic        rdy;
        logic [3:0]  clr;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed view: {valid, ch[1:0], pol, pending[3:0], ovf[3:0]}
    function automatic logic [11:0] snap();
        return {ev_if.ev_valid, ev_if.ev_ch, ev_if.ev_pol, pending, ovf};
    endfunction

    function automatic logic [11:0] pk(logic v, logic [1:0] ch, logic pol,
                                       logic [3:0] pend, logic [3:0] ov);
        return {v, ch, pol, pend, ov};
    endfunction

    task automatic add(logic [3:0] dd, logic [7:0] md, logic rdy, logic [3:0] clr,
                       logic v, logic [1:0] ch, logic pol, logic [3:0] pend, logic [3:0] ov);
        vec_t t;
        t.d = dd; t.mode = md; t.rdy = rdy; t.clr = clr;
        t.exp = pk(v, ch, pol, pend, ov);
        vecs.push_back(t);
    endtask

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {v,ch,pol,pend,ovf}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     name, act[11], act[10:9], act[8], act[7:4], act[3:0],
                     exp[11], exp[10:9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        d = 4'b0000;
        mode = 8'hFF;
        ovf_clr = 4'b0000;
        ev_if.ev_ready = 1'b0;

        //   d        mode   rdy  clr       v  ch  pol pend     ovf
        add(4'b0000, 8'hFF, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000); // 0 idle
        add(4'b0100, 8'hFF, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000); // 1 ch2 rise
        add(4'b0100, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000); // 2 presented
        add(4'b0100, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000); // 3 held
        add(4'b0100, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000); // 4 accepted
        add(4'b0110, 8'h04, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0010, 4'b0000); // 5 ch1 rise, mode 01
        add(4'b0100, 8'h04, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000); // 6 fall ignored
        add(4'b0100, 8'h04, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000); // 7
        add(4'b0110, 8'h08, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000); // 8 rise ignored, mode 10
        add(4'b0100, 8'h08, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0010, 4'b0000); // 9 fall pends
        add(4'b0100, 8'h08, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000); // 10 pol 0
        add(4'b0100, 8'h08, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000); // 11
        add(4'b1011, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000); // 12 mode off
        add(4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000); // 13
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b1111, 4'b0000); // 14 all rise
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1011, 4'b0000); // 15 rr after ch1
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0011, 4'b0000); // 16
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0000); // 17
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000); // 18
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000); // 19
        add(4'b1110, 8'hFF, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0001, 4'b0000); // 20 ch0 fall
        add(4'b1110, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000); // 21 stalled
        add(4'b1111, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000); // 22 second edge
        add(4'b1110, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0001); // 23 third -> ovf
        add(4'b1110, 8'hFF, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000); // 24 clr
        add(4'b1111, 8'hFF, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0001); // 25 set beats clr
        add(4'b1111, 8'hFF, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0001); // 26 sticky
        add(4'b1111, 8'hFF, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000); // 27 newest pol
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000); // 28
        add(4'b1101, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000); // 29 ch1 fall
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000); // 30 pop collision
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000); // 31 second ch1
        add(4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000); // 32

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", snap(), 12'b0);
        @(negedge clk);
        rstn = 1'b1;
        #4;

        foreach (vecs[i]) begin
            d = vecs[i].d;
            mode = vecs[i].mode;
            ev_if.ev_ready = vecs[i].rdy;
            ovf_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end
        ovf_clr = 4'b0000;

        // Backpressure: one event presented, ready low for 10 cycles
        ev_if.ev_ready = 1'b0;
        d = 4'b1110;
        step();
        chk("bp_pend", snap(), pk(1'b0, 2'd1, 1'b1, 4'b0001, 4'b0000));
        step();
        chk("bp_load", snap(), pk(1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("bp_hold%0d", k), snap(), pk(1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000));
        end
        d = 4'b1111;
        step();
        chk("bp_repend", snap(), pk(1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000));

        // Async reset mid-cycle with an event presented and one pending
        #2;
        rstn = 1'b0;
        d = 4'b0000;
        #1;
        chk("async_reset", snap(), 12'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #4;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("post_reset%0d", k), snap(), 12'b0);
        end

        // Round robin from reset: channel 0 first
        ev_if.ev_ready = 1'b1;
        d = 4'b1111;
        step();
        chk("rr_pend", snap(), pk(1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000));
        step();
        chk("rr_ch0", snap(), pk(1'b1, 2'd0, 1'b1, 4'b1110, 4'b0000));
        step();
        chk("rr_ch1", snap(), pk(1'b1, 2'd1, 1'b1, 4'b1100, 4'b0000));
        step();
        chk("rr_ch2", snap(), pk(1'b1, 2'd2, 1'b1, 4'b1000, 4'b0000));
        step();
        chk("rr_ch3", snap(), pk(1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000));
        step();
        chk("rr_idle", snap(), pk(1'b0, 2'd3, 1'b1, 4'b0000, 4'b0000));

        // After a ch0 grant, ch3 is served before the re-armed ch0
        d = 4'b1110;
        step();
        chk("rr2_pend0", snap(), pk(1'b0, 2'd3, 1'b1, 4'b0001, 4'b0000));
        d = 4'b0111;
        step();
        chk("rr2_ch0", snap(), pk(1'b1, 2'd0, 1'b0, 4'b1001, 4'b0000));
        step();
        chk("rr2_ch3", snap(), pk(1'b1, 2'd3, 1'b0, 4'b0001, 4'b0000));
        step();
        chk("rr2_ch0b", snap(), pk(1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000));
        step();
        chk("rr2_idle", snap(), pk(1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
